m_down_timer: RTL and testbench
===============================

Name: m_down_timer

Overview:
- Loadable down-counting timer. It is the counterpart of the free-running up counters used in the lab designs: it counts toward zero and flags expiry.
- Software-style controls: load, start, stop, and one-shot vs periodic mode. Exposes count, state, a one-cycle expiry pulse and a saturating expiry tally.
- Sits beside the counter blocks as the timebase/event generator for later lab exercises.

Parameters:
- WIDTH, 8, width of count, load value and reload register.
- NEXP_W, 8, width of the saturating expiry counter.

Ports:
- w_clk  input  1  clock; all state updates on posedge.
- w_rst  input  1  synchronous active-high reset.
- w_load  input  1  load request, sampled each posedge.
- w_load_val  input  WIDTH  value captured on load.
- w_start  input  1  start/resume request.
- w_stop  input  1  pause request.
- w_periodic  input  1  1 = auto-reload on expiry; sampled at each expiry.
- w_cnt  output  WIDTH  current count (registered).
- w_state  output  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
- w_busy  output  1  1 iff state == RUN (combinational decode of state).
- w_expire  output  1  registered pulse, high exactly one cycle per expiry.
- w_nexp  output  NEXP_W  number of expiries since last load, saturating.

Behaviour:
- Internal registers: r_cnt, r_reload, r_state, r_expire, r_nexp; all outputs driven from them.
- Reset: when w_rst is 1 at a posedge, all registers become 0 (state IDLE, cnt 0, reload 0, expire 0, nexp 0). This holds in any state, including mid-RUN.
- Input priority per edge: rst > stop > load > start.
- w_expire defaults to 0 every edge unless an expiry occurs on that edge.
- IDLE / PAUSE / DONE (not running):
  - load: r_cnt <= w_load_val, r_reload <= w_load_val, r_nexp <= 0.
  - start, same edge or later:
    - value = w_load_val if load is asserted this edge, else r_cnt; if that is 0, use r_reload.
    - If value != 0: r_cnt <= value, state <= RUN.
    - If value == 0: start is ignored and state is unchanged.
  - stop while not running: no effect.
- RUN:
  - stop: state <= PAUSE, r_cnt holds, no decrement on that edge, and any expiry that would occur on that edge is suppressed.
  - load: updates r_reload only, and clears r_nexp. r_cnt keeps counting; the new value takes effect at the next reload.
  - start while running: ignored.
  - Otherwise, each edge with r_cnt > 1: r_cnt <= r_cnt - 1.
  - Edge with r_cnt == 1 (expiry):
    - r_expire <= 1.
    - r_nexp <= r_nexp + 1, saturating at 2^NEXP_W - 1.
    - If w_periodic: r_cnt <= r_reload and state stays RUN. If r_reload == 0: r_cnt <= 0 and state <= DONE.
    - Else: r_cnt <= 0, state <= DONE.
- Latency and periods:
  - Start with value N: w_expire is high N edges after the start edge.
  - Periodic mode with reload R: w_expire repeats every R cycles.
  - WIDTH=8 supports N up to 255; there is no wrap below zero, and r_cnt never underflows.
- load and expiry on the same edge in RUN: r_nexp <= 1 (the expiry is counted after the clear) and r_reload takes w_load_val. In periodic mode, the reload on that edge uses the new w_load_val.
- DONE is sticky: it holds r_cnt = 0 until load, start (which reuses r_reload) or reset.

Test Plan:
- Reset mid-RUN: load 200, start, wait 10 cycles, assert w_rst for 1 edge -> next cycle state 0, cnt 0, nexp 0, expire 0.
- One-shot: load 3, start on the next edge -> cnt 3,2,1,0. w_expire is high only in the cycle where cnt first reads 0, then state 3 and busy 0; nexp 1.
- Periodic: load 4 with start on the same edge, w_periodic=1, run 13 cycles -> cnt 4,3,2,1,4,3,2,1,4,... One w_expire pulse every 4 cycles; nexp 3 after the third pulse; state stays 1.
- Pause/resume: load 10, start, stop when cnt=6 -> state 2, cnt holds 6 for 5 cycles. Then start -> counts 5..1..0; expire 6 cycles after resume.
- Load while running: load 5, start, periodic, load 2 when cnt=3 -> cnt 2,1,2,1,2,1... after the first expiry; nexp resets to 0 at the load edge.
- Edge cases: start with load_val 0 in IDLE -> state stays 0. Stop+start on the same edge in RUN -> PAUSE. NEXP_W=2 with load 1 periodic -> nexp saturates at 3 while expire keeps pulsing every cycle.

Source files
------------

// File: rtl/m_down_timer.sv
// Loadable down-counting timer with one-shot/periodic modes, pause/resume,
// a one-cycle expiry pulse and a saturating count of expiries since the last load.
module m_down_timer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NEXP_W = 8
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_load,
    input  logic [WIDTH-1:0]  w_load_val,
    input  logic              w_start,
    input  logic              w_stop,
    input  logic              w_periodic,
    output logic [WIDTH-1:0]  w_cnt,
    output logic [1:0]        w_state,
    output logic              w_busy,
    output logic              w_expire,
    output logic [NEXP_W-1:0] w_nexp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [NEXP_W-1:0] NEXP_MAX = '1;

    state_t              r_state;
    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_reload;
    logic                r_expire;
    logic [NEXP_W-1:0]   r_nexp;

    logic [WIDTH-1:0]    w_start_raw;
    logic [WIDTH-1:0]    w_reload_nxt;
    logic [WIDTH-1:0]    w_start_val;
    logic [NEXP_W-1:0]   w_nexp_base;
    logic [NEXP_W-1:0]   w_nexp_inc;

    // A load on the same edge takes effect before start/expiry evaluate.
    assign w_start_raw  = w_load ? w_load_val : r_cnt;
    assign w_reload_nxt = w_load ? w_load_val : r_reload;
    assign w_start_val  = (w_start_raw != '0) ? w_start_raw : w_reload_nxt;
    assign w_nexp_base  = w_load ? '0 : r_nexp;
    assign w_nexp_inc   = (w_nexp_base == NEXP_MAX) ? w_nexp_base
                                                    : w_nexp_base + NEXP_W'(1);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_reload <= '0;
            r_expire <= 1'b0;
            r_nexp   <= '0;
        end else begin
            r_expire <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_stop) begin
                        r_state <= S_PAUSE;
                    end else begin
                        if (w_load) begin
                            r_reload <= w_load_val;
                            r_nexp   <= '0;
                        end
                        if (r_cnt > WIDTH'(1)) begin
                            r_cnt <= r_cnt - WIDTH'(1);
                        end else begin
                            // Expiry edge; a zero reload ends periodic mode.
                            r_expire <= 1'b1;
                            r_nexp   <= w_nexp_inc;
                            if (w_periodic && (w_reload_nxt != '0)) begin
                                r_cnt <= w_reload_nxt;
                            end else begin
                                r_cnt   <= '0;
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                default: begin
                    if (w_load) begin
                        r_cnt    <= w_load_val;
                        r_reload <= w_load_val;
                        r_nexp   <= '0;
                    end
                    if (w_start && (w_start_val != '0)) begin
                        r_cnt   <= w_start_val;
                        r_state <= S_RUN;
                    end
                end
            endcase
        end
    end

    assign w_cnt    = r_cnt;
    assign w_state  = r_state;
    assign w_busy   = (r_state == S_RUN);
    assign w_expire = r_expire;
    assign w_nexp   = r_nexp;

endmodule

// File: tb/tb_m_down_timer.sv
// Directed bench for m_down_timer; a second instance with NEXP_W=2 covers tally saturation.
module tb_m_down_timer;

    logic       clk = 1'b0;
    logic       rst, load, start, stop, periodic;
    logic [7:0] load_val;

    logic [7:0] a_cnt;
    logic [1:0] a_state;
    logic       a_busy, a_expire;
    logic [7:0] a_nexp;

    logic [7:0] b_cnt;
    logic [1:0] b_state;
    logic       b_busy, b_expire;
    logic [1:0] b_nexp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    m_down_timer #(.WIDTH(8), .NEXP_W(8)) u_a (
        .w_clk(clk), .w_rst(rst), .w_load(load), .w_load_val(load_val),
        .w_start(start), .w_stop(stop), .w_periodic(periodic),
        .w_cnt(a_cnt), .w_state(a_state), .w_busy(a_busy),
        .w_expire(a_expire), .w_nexp(a_nexp)
    );

    m_down_timer #(.WIDTH(8), .NEXP_W(2)) u_b (
        .w_clk(clk), .w_rst(rst), .w_load(load), .w_load_val(load_val),
        .w_start(start), .w_stop(stop), .w_periodic(periodic),
        .w_cnt(b_cnt), .w_state(b_state), .w_busy(b_busy),
        .w_expire(b_expire), .w_nexp(b_nexp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; request pulses are dropped after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; periodic = 1'b0; load_val = 8'd0;
        tick();
        chk("rst_state", a_state, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_nexp", a_nexp, 0);
        chk("rst_expire", a_expire, 0);
        chk("rst_busy", a_busy, 0);

        // Reset in the middle of a run
        load = 1'b1; load_val = 8'd200; tick();
        start = 1'b1; tick();
        repeat (10) tick();
        chk("mid_cnt", a_cnt, 190);
        chk("mid_busy", a_busy, 1);
        rst = 1'b1; tick();
        chk("midrst_state", a_state, 0);
        chk("midrst_cnt", a_cnt, 0);
        chk("midrst_nexp", a_nexp, 0);
        chk("midrst_expire", a_expire, 0);

        // One-shot
        load = 1'b1; load_val = 8'd3; tick();
        chk("os_load_cnt", a_cnt, 3);
        chk("os_load_state", a_state, 0);
        start = 1'b1; tick();
        chk("os_cnt3", a_cnt, 3);
        chk("os_busy", a_busy, 1);
        tick();
        chk("os_cnt2", a_cnt, 2);
        tick();
        chk("os_cnt1", a_cnt, 1);
        chk("os_exp_early", a_expire, 0);
        tick();
        chk("os_cnt0", a_cnt, 0);
        chk("os_expire", a_expire, 1);
        chk("os_state_done", a_state, 3);
        chk("os_busy_done", a_busy, 0);
        chk("os_nexp", a_nexp, 1);
        tick();
        chk("os_expire_once", a_expire, 0);
        chk("os_done_sticky", a_state, 3);
        chk("os_done_cnt", a_cnt, 0);

        // Periodic, load and start on the same edge
        periodic = 1'b1; load = 1'b1; start = 1'b1; load_val = 8'd4; tick();
        chk("per_cnt_start", a_cnt, 4);
        chk("per_nexp_clr", a_nexp, 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("per_cnt", a_cnt, 32'(4 - (i % 4)));
            chk("per_expire", a_expire, (i % 4 == 0) ? 1 : 0);
            chk("per_nexp", a_nexp, 32'(i / 4));
        end
        chk("per_state", a_state, 1);

        // Pause and resume
        periodic = 1'b0; rst = 1'b1; tick();
        load = 1'b1; load_val = 8'd10; tick();
        start = 1'b1; tick();
        chk("pr_cnt10", a_cnt, 10);
        repeat (4) tick();
        chk("pr_cnt6", a_cnt, 6);
        stop = 1'b1; tick();
        chk("pr_pause_state", a_state, 2);
        chk("pr_pause_cnt", a_cnt, 6);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pr_hold_cnt", a_cnt, 6);
            chk("pr_hold_state", a_state, 2);
        end
        start = 1'b1; tick();
        chk("pr_resume_state", a_state, 1);
        chk("pr_resume_cnt", a_cnt, 6);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("pr_run_cnt", a_cnt, 32'(6 - i));
            chk("pr_run_expire", a_expire, 0);
        end
        tick();
        chk("pr_end_cnt", a_cnt, 0);
        chk("pr_end_expire", a_expire, 1);
        chk("pr_end_state", a_state, 3);

        // Load while running in periodic mode
        rst = 1'b1; tick();
        periodic = 1'b1; load = 1'b1; start = 1'b1; load_val = 8'd5; tick();
        repeat (4) tick();
        chk("lr_cnt1", a_cnt, 1);
        tick();
        chk("lr_exp1", a_expire, 1);
        chk("lr_reload5", a_cnt, 5);
        chk("lr_nexp1", a_nexp, 1);
        tick(); tick();
        chk("lr_cnt3", a_cnt, 3);
        load = 1'b1; load_val = 8'd2; tick();
        chk("lr_load_cnt", a_cnt, 2);
        chk("lr_load_nexp", a_nexp, 0);
        chk("lr_load_state", a_state, 1);
        tick();
        chk("lr_cnt1b", a_cnt, 1);
        tick();
        chk("lr_newreload", a_cnt, 2);
        chk("lr_exp2", a_expire, 1);
        chk("lr_nexp_after", a_nexp, 1);
        tick();
        chk("lr_cnt1c", a_cnt, 1);
        load = 1'b1; load_val = 8'd7; tick();
        chk("lr_same_edge_cnt", a_cnt, 7);
        chk("lr_same_edge_exp", a_expire, 1);
        chk("lr_same_edge_nexp", a_nexp, 1);

        // Start with zero value is ignored; stop beats start while running
        periodic = 1'b0; rst = 1'b1; tick();
        load_val = 8'd0; start = 1'b1; tick();
        chk("zero_start_state", a_state, 0);
        load = 1'b1; start = 1'b1; load_val = 8'd9; tick();
        chk("ss_cnt9", a_cnt, 9);
        tick();
        chk("ss_cnt8", a_cnt, 8);
        stop = 1'b1; start = 1'b1; tick();
        chk("ss_state", a_state, 2);
        chk("ss_cnt", a_cnt, 8);

        // Saturating expiry tally on the narrow instance
        rst = 1'b1; tick();
        periodic = 1'b1; load = 1'b1; start = 1'b1; load_val = 8'd1; tick();
        chk("sat_cnt", b_cnt, 1);
        chk("sat_state", b_state, 1);
        chk("sat_nexp0", b_nexp, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("sat_nexp", b_nexp, (i < 3) ? 32'(i) : 32'd3);
            chk("sat_expire", b_expire, 1);
            chk("sat_cnt_run", b_cnt, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
